// File: rtl/regfile_scoreboard.sv
// Parametrised register file (R0 reads zero) with a per-register busy scoreboard and reserve handshake.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write-back data to the read ports.
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   rs1_addr,
    input  logic [ADDR_W-1:0]   rs2_addr,
    output logic [DATA_W-1:0]   rs1_data,
    output logic [DATA_W-1:0]   rs2_data,
    output logic                rs1_busy,
    output logic                rs2_busy,
    input  logic                rsv_valid,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic                rsv_ready,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                wb_err
);

    localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

    // R0 has no storage; it is implied by the read muxes defaulting to zero.
    logic [DATA_W-1:0]   regs_q [1:NUM_REGS-1];
    logic [DATA_W-1:0]   regs_d [1:NUM_REGS-1];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                wbErr_q;
    logic                wbErr_d;

    logic [DATA_W-1:0]   rs1DataRaw;
    logic [DATA_W-1:0]   rs2DataRaw;
    logic                rs1BusyRaw;
    logic                rs2BusyRaw;
    logic                rsvBusy;
    logic                wbBusy;
    logic                wbInRange;
    logic                rsvInRange;
    logic                wbHit;
    logic                busyEff;
    logic                rsvSet;

    // Shared lookup muxes; address 0 and out-of-range addresses fall through to zero.
    always_comb begin
        rs1DataRaw = '0;
        rs2DataRaw = '0;
        rs1BusyRaw = 1'b0;
        rs2BusyRaw = 1'b0;
        rsvBusy    = 1'b0;
        wbBusy     = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs1_addr == ADDR_W'(i)) begin
                rs1DataRaw = regs_q[i];
                rs1BusyRaw = busy_q[i];
            end
            if (rs2_addr == ADDR_W'(i)) begin
                rs2DataRaw = regs_q[i];
                rs2BusyRaw = busy_q[i];
            end
            if (rsv_addr == ADDR_W'(i)) begin
                rsvBusy = busy_q[i];
            end
            if (wb_addr == ADDR_W'(i)) begin
                wbBusy = busy_q[i];
            end
        end
    end

    always_comb begin
        wbInRange  = ({1'b0, wb_addr} < NUM_REGS_A);
        rsvInRange = ({1'b0, rsv_addr} < NUM_REGS_A);
        wbHit      = wb_valid && wbInRange && (wb_addr != '0);
        wbErr_d    = wb_valid && (!wbInRange || (wbHit && !wbBusy));
        // A same-cycle write-back releases the register, so it can be re-reserved at once.
        busyEff    = rsvBusy && !(wb_valid && (wb_addr == rsv_addr));
        rsv_ready  = rsv_valid && ((rsv_addr == '0) || (rsvInRange && !busyEff));
        rsvSet     = rsv_ready && (rsv_addr != '0);
    end

    // Write-back clears busy first so an accepted reserve of the same register wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wbHit && (wb_addr == ADDR_W'(i))) begin
                regs_d[i] = wb_data;
                busy_d[i] = 1'b0;
            end
            if (rsvSet && (rsv_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q  <= '0;
            wbErr_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            wbErr_q <= wbErr_d;
        end
    end

    assign busy_vec = busy_q;
    assign wb_err   = wbErr_q;

`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write-back; busy only survives if the register is re-reserved now.
    always_comb begin
        rs1_data = rs1DataRaw;
        rs1_busy = rs1BusyRaw;
        rs2_data = rs2DataRaw;
        rs2_busy = rs2BusyRaw;
        if (wbHit && (wb_addr == rs1_addr)) begin
            rs1_data = wb_data;
            rs1_busy = rsvSet && (rsv_addr == rs1_addr);
        end
        if (wbHit && (wb_addr == rs2_addr)) begin
            rs2_data = wb_data;
            rs2_busy = rsvSet && (rsv_addr == rs2_addr);
        end
    end
`else
    assign rs1_data = rs1DataRaw;
    assign rs1_busy = rs1BusyRaw;
    assign rs2_data = rs2DataRaw;
    assign rs2_busy = rs2BusyRaw;
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard; a second instance with NUM_REGS=6
// exercises out-of-range addresses.
module tb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  rs1_addr, rs2_addr, rsv_addr, wb_addr;
    logic        rsv_valid, wb_valid;
    logic [15:0] wb_data;

    logic [15:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy, rsv_ready, wb_err;
    logic [7:0]  busy_vec;

    logic [15:0] rs1_data2, rs2_data2;
    logic        rs1_busy2, rs2_busy2, rsv_ready2, wb_err2;
    logic [5:0]  busy_vec2;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clock = ~clock;

    regfile_scoreboard dut (
        .clock(clock), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy_vec(busy_vec), .wb_err(wb_err)
    );

    regfile_scoreboard #(.DATA_W(16), .NUM_REGS(6), .ADDR_W(3)) dut2 (
        .clock(clock), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data2), .rs2_data(rs2_data2),
        .rs1_busy(rs1_busy2), .rs2_busy(rs2_busy2),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready2),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy_vec(busy_vec2), .wb_err(wb_err2)
    );

    task automatic idle();
        reset     = 1'b0;
        rsv_valid = 1'b0;
        rsv_addr  = 3'd0;
        wb_valid  = 1'b0;
        wb_addr   = 3'd0;
        wb_data   = 16'h0000;
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rs1_addr = 3'(a);
            rs2_addr = 3'(7 - a);
            #1;
            testsRun++;
            if (rs1_data !== 16'h0000 || rs1_busy !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset_rs1[%0d]: got data=%h busy=%b, want 0000/0", a, rs1_data, rs1_busy);
            end
            testsRun++;
            if (rs2_data !== 16'h0000 || rs2_busy !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset_rs2[%0d]: got data=%h busy=%b, want 0000/0", 7 - a, rs2_data, rs2_busy);
            end
        end
        testsRun++;
        if (busy_vec !== 8'h00 || wb_err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: got busy_vec=%h wb_err=%b, want 00/0", busy_vec, wb_err);
        end
    endtask

    task automatic test_reserve_wb();
        idle();
        rsv_valid = 1'b1;
        rsv_addr  = 3'd3;
        #1;
        testsRun++;
        if (rsv_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rsv_r3_ready: got %b, want 1", rsv_ready);
        end
        tick();
        idle();
        rs1_addr = 3'd3;
        #1;
        testsRun++;
        if (rs1_busy !== 1'b1 || busy_vec !== 8'h08) begin
            testsFailed++;
            $display("[TB] FAIL r3_busy: got rs1_busy=%b busy_vec=%h, want 1/08", rs1_busy, busy_vec);
        end
        wb_valid = 1'b1;
        wb_addr  = 3'd3;
        wb_data  = 16'hBEEF;
        tick();
        idle();
        testsRun++;
        if (rs1_data !== 16'hBEEF || rs1_busy !== 1'b0 || busy_vec !== 8'h00 || wb_err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL wb_r3: got data=%h busy=%b busy_vec=%h wb_err=%b, want BEEF/0/00/0",
                     rs1_data, rs1_busy, busy_vec, wb_err);
        end
    endtask

    task automatic test_waw();
        idle();
        rsv_valid = 1'b1;
        rsv_addr  = 3'd3;
        tick();
        #1;
        testsRun++;
        if (rsv_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL waw_refused: got rsv_ready=%b, want 0", rsv_ready);
        end
        tick();
        testsRun++;
        if (busy_vec !== 8'h08) begin
            testsFailed++;
            $display("[TB] FAIL waw_busy_vec: got %h, want 08", busy_vec);
        end
        wb_valid = 1'b1;
        wb_addr  = 3'd3;
        wb_data  = 16'h5555;
        #1;
        testsRun++;
        if (rsv_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL wb_rsv_same_ready: got %b, want 1", rsv_ready);
        end
        tick();
        idle();
        rs1_addr = 3'd3;
        #1;
        testsRun++;
        if (rs1_data !== 16'h5555 || busy_vec !== 8'h08 || wb_err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL wb_rsv_same: got data=%h busy_vec=%h wb_err=%b, want 5555/08/0",
                     rs1_data, busy_vec, wb_err);
        end
        wb_valid = 1'b1;
        wb_addr  = 3'd3;
        wb_data  = 16'h5555;
        tick();
        idle();
    endtask

    task automatic test_wb_err();
        idle();
        wb_valid = 1'b1;
        wb_addr  = 3'd5;
        wb_data  = 16'h1234;
        tick();
        idle();
        rs2_addr = 3'd5;
        #1;
        testsRun++;
        if (rs2_data !== 16'h1234 || wb_err !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL wb_nonbusy: got data=%h wb_err=%b, want 1234/1", rs2_data, wb_err);
        end
        tick();
        testsRun++;
        if (wb_err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL wb_err_pulse: got %b, want 0", wb_err);
        end
        wb_valid = 1'b1;
        wb_addr  = 3'd0;
        wb_data  = 16'hFFFF;
        tick();
        idle();
        rs1_addr = 3'd0;
        #1;
        testsRun++;
        if (rs1_data !== 16'h0000 || wb_err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL wb_r0: got data=%h wb_err=%b, want 0000/0", rs1_data, wb_err);
        end
        rsv_valid = 1'b1;
        rsv_addr  = 3'd0;
        #1;
        testsRun++;
        if (rsv_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rsv_r0_ready: got %b, want 1", rsv_ready);
        end
        tick();
        idle();
        testsRun++;
        if (busy_vec !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL rsv_r0_state: got busy_vec=%h, want 00", busy_vec);
        end
    endtask

    task automatic test_diff_regs();
        idle();
        rsv_valid = 1'b1;
        rsv_addr  = 3'd1;
        tick();
        rsv_addr  = 3'd7;
        wb_valid  = 1'b1;
        wb_addr   = 3'd1;
        wb_data   = 16'h1111;
        #1;
        testsRun++;
        if (rsv_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL diff_ready: got %b, want 1", rsv_ready);
        end
        tick();
        idle();
        rs1_addr = 3'd1;
        rs2_addr = 3'd7;
        #1;
        testsRun++;
        if (rs1_data !== 16'h1111 || rs2_busy !== 1'b1 || busy_vec !== 8'h80 || wb_err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL diff_regs: got data=%h rs2_busy=%b busy_vec=%h wb_err=%b, want 1111/1/80/0",
                     rs1_data, rs2_busy, busy_vec, wb_err);
        end
        wb_valid = 1'b1;
        wb_addr  = 3'd7;
        wb_data  = 16'h7777;
        tick();
        idle();
    endtask

    task automatic test_bypass();
        idle();
        rsv_valid = 1'b1;
        rsv_addr  = 3'd6;
        tick();
        idle();
        wb_valid = 1'b1;
        wb_addr  = 3'd6;
        wb_data  = 16'h00AA;
        rs2_addr = 3'd6;
        #1;
        testsRun++;
`ifdef REGFILE_BYPASS_EN
        if (rs2_data !== 16'h00AA || rs2_busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bypass_same_cycle: got data=%h busy=%b, want 00AA/0", rs2_data, rs2_busy);
        end
`else
        if (rs2_data !== 16'h0000 || rs2_busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL no_bypass_same_cycle: got data=%h busy=%b, want 0000/1", rs2_data, rs2_busy);
        end
`endif
        tick();
        idle();
        testsRun++;
        if (rs2_data !== 16'h00AA || rs2_busy !== 1'b0 || busy_vec !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL bypass_after_edge: got data=%h busy=%b busy_vec=%h, want 00AA/0/00",
                     rs2_data, rs2_busy, busy_vec);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        rsv_valid = 1'b1;
        rsv_addr  = 3'd2;
        tick();
        rsv_addr  = 3'd4;
        tick();
        idle();
        testsRun++;
        if (busy_vec !== 8'h14) begin
            testsFailed++;
            $display("[TB] FAIL pre_reset_busy: got %h, want 14", busy_vec);
        end
        reset     = 1'b1;
        wb_valid  = 1'b1;
        wb_addr   = 3'd2;
        wb_data   = 16'hDEAD;
        rsv_valid = 1'b1;
        rsv_addr  = 3'd1;
        tick();
        idle();
        testsRun++;
        if (busy_vec !== 8'h00 || wb_err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_state: got busy_vec=%h wb_err=%b, want 00/0", busy_vec, wb_err);
        end
        for (int a = 1; a < 8; a++) begin
            rs1_addr = 3'(a);
            #1;
            testsRun++;
            if (rs1_data !== 16'h0000) begin
                testsFailed++;
                $display("[TB] FAIL mid_reset_r%0d: got %h, want 0000", a, rs1_data);
            end
        end
    endtask

    task automatic test_out_of_range();
        idle();
        rs1_addr = 3'd7;
        rs2_addr = 3'd6;
        rsv_valid = 1'b1;
        rsv_addr  = 3'd6;
        #1;
        testsRun++;
        if (rsv_ready2 !== 1'b0 || rs1_data2 !== 16'h0000 || rs1_busy2 !== 1'b0 || rs2_data2 !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL oor_reads: got ready=%b d1=%h b1=%b d2=%h, want 0/0000/0/0000",
                     rsv_ready2, rs1_data2, rs1_busy2, rs2_data2);
        end
        rsv_valid = 1'b0;
        wb_valid  = 1'b1;
        wb_addr   = 3'd7;
        wb_data   = 16'hCAFE;
        tick();
        idle();
        testsRun++;
        if (wb_err2 !== 1'b1 || busy_vec2 !== 6'h00 || rs1_data2 !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL oor_wb: got wb_err=%b busy_vec=%h data=%h, want 1/00/0000",
                     wb_err2, busy_vec2, rs1_data2);
        end
        tick();
        testsRun++;
        if (wb_err2 !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL oor_wb_pulse: got %b, want 0", wb_err2);
        end
    endtask

    initial begin
        rs1_addr = 3'd0;
        rs2_addr = 3'd0;
        idle();
        @(negedge clock);
        test_reset();
        test_reserve_wb();
        test_waw();
        test_wb_err();
        test_diff_regs();
        test_bypass();
        test_reset_mid();
        test_out_of_range();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the 8x16 register file.
- Generic width and register count; register 0 hardwired to zero; two asynchronous read ports; one write-back port.
- Adds a per-register scoreboard (busy bits) with a reserve handshake, so the control unit can detect RAW/WAW hazards in multi-cycle or overlapped execution.
- Sits between the decode/control unit (reserve, reads) and the ALU/memory write-back path.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 8, number of registers (>=2); register 0 reads as zero.
- ADDR_W, 3, register address width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- rs1_addr  in  ADDR_W  read port 1 register select.
- rs2_addr  in  ADDR_W  read port 2 register select.
- rs1_data  out  DATA_W  read port 1 data (combinational).
- rs2_data  out  DATA_W  read port 2 data (combinational).
- rs1_busy  out  1  selected register has a pending write (combinational).
- rs2_busy  out  1  as rs1_busy, for port 2.
- rsv_valid  in  1  request to reserve rsv_addr as a future write destination.
- rsv_addr  in  ADDR_W  destination to reserve.
- rsv_ready  out  1  reservation accepted this cycle (combinational).
- wb_valid  in  1  write-back strobe.
- wb_addr  in  ADDR_W  write-back destination.
- wb_data  in  DATA_W  write-back data.
- busy_vec  out  NUM_REGS  registered busy bits; bit 0 always 0.
- wb_err  out  1  registered one-cycle pulse: write-back to a non-busy or out-of-range register.

Behaviour:
- Reset: on a clock edge with reset=1, all registers clear to 0, busy_vec clears to 0 and wb_err clears to 0. Reset mid-operation discards all pending reservations and ignores any wb/rsv inputs in that cycle.
- Reads:
  - rsN_data = 0 if rsN_addr==0 or rsN_addr>=NUM_REGS; otherwise registers[rsN_addr].
  - rsN_busy = busy_vec[rsN_addr], forced to 0 for address 0 or out-of-range addresses.
- Write-back (wb_valid=1, wb_addr in 1..NUM_REGS-1):
  - registers[wb_addr] <= wb_data on the next edge.
  - busy bit clears, unless a reservation of the same register is accepted in the same cycle.
  - Writes land whether or not the register was busy. If it was not busy, wb_err pulses for 1 cycle.
- Write-back to address 0: ignored, no wb_err. Write-back to an out-of-range address: ignored, wb_err pulses.
- Reserve handshake:
  - rsv_ready = rsv_valid & (rsv_addr==0 | (rsv_addr<NUM_REGS & !busy_eff)).
  - busy_eff = busy_vec[rsv_addr] & !(wb_valid & wb_addr==rsv_addr). A write-back in the same cycle frees the register for immediate reservation.
  - Accepted reserve of a nonzero register sets its busy bit on the next edge.
  - Reserve of R0 is accepted with no state change.
  - Reserve of a busy register (WAW) is refused: rsv_ready=0 and no state change. The requester holds rsv_valid/rsv_addr until rsv_ready is seen.
- Simultaneous write-back and accepted reserve to the same register: data written, busy stays 1 (the new producer owns it).
- Write-back and reserve to different registers in the same cycle: both take effect independently.
- Latency: reads combinational, 0 cycles. Writes and busy updates visible 1 cycle after the edge.
- No read-during-write forwarding unless REGFILE_BYPASS_EN is defined.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when wb_valid=1 and wb_addr==rsN_addr!=0 (in range), rsN_data returns wb_data and rsN_busy returns 0 in the same cycle, unless an accepted reserve of the same address occurs that cycle (busy then reads 1).
- Undefined: reads return the stored value until the edge; rsN_busy reflects busy_vec only.

Test Plan:
- Reset, then read all addresses on both ports -> data 0, busy 0, busy_vec=0, wb_err=0.
- Reserve R3 (rsv_ready=1); next cycle rs1_addr=3 -> rs1_busy=1; wb R3=16'hBEEF -> next cycle rs1_data=16'hBEEF, rs1_busy=0, busy_vec[3]=0.
- R3 busy, reserve R3 again -> rsv_ready=0, busy_vec unchanged; same-cycle wb R3 and reserve R3 -> rsv_ready=1, R3 updated, busy_vec[3] stays 1.
- wb to non-busy R5 with 16'h1234 -> R5=16'h1234, wb_err pulses exactly 1 cycle. wb to R0 with 16'hFFFF -> rs1_data(0)=0, no wb_err. Reserve R0 -> rsv_ready=1, busy_vec[0]=0.
- Reserve R2 and R4, then assert reset with wb R2 pending -> after the edge busy_vec=0 and all registers 0.
- R6 busy, wb R6=16'h00AA with rs2_addr=6 -> with REGFILE_BYPASS_EN same-cycle rs2_data=16'h00AA, rs2_busy=0; without it old value and busy=1 until the edge.
